// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, line levels and the FSM state encoding.
// Imported by both the transmitter and the receiver so their framing stays identical.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count on tick.
// clear restarts the period from 0 on the next edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == TERM);

    // NOTE: cnt_d gets its default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: valid/ready byte intake, one-entry holding register, 11-bit frame shifter.
// Define UART_TX_PARITY_EN to carry even parity in the parity slot; otherwise it is driven high.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      send,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_full_q, hold_full_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      parity_q, parity_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic tick;
    logic clear;
    logic load;
    logic move;
    logic slot_bit;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .tick (tick)
    );

`ifdef UART_TX_PARITY_EN
    assign slot_bit = even_parity(hold_q);
`else
    assign slot_bit = 1'b1;
`endif

    // Load needs an empty holding register and move needs a full one, so they never coincide.
    assign load  = send && !hold_full_q;
    assign move  = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && tick));
    assign clear = (state_q == IDLE) || (state_d != state_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;

        if (load) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end
        if (move) begin
            shift_d     = hold_q;
            parity_d    = slot_bit;
            hold_full_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = hold_full_q ? START : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line outputs are registered from the current state, so tx/busy/done trail the FSM by one edge.
    always_comb begin
        tx_d   = UART_IDLE_LEVEL;
        busy_d = (state_q != IDLE);
        done_d = (state_q == STOP) && tick;
        unique case (state_q)
            IDLE:    tx_d = UART_IDLE_LEVEL;
            START:   tx_d = UART_START_LEVEL;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = parity_q;
            STOP:    tx_d = UART_STOP_LEVEL;
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // NOTE: the byte registers are reset too, so a mid-frame reset leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b1;
            bit_idx_q   <= '0;
            tx_q        <= UART_IDLE_LEVEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ready = !hold_full_q;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
